// File: rtl/invaders_video_fetch.sv
// Raster timing and 1bpp bitmap fetch for the 8080 video board: H/V counters,
// syncs, video RAM byte fetch, pixel shifter, colour PROM address and RST 1/2 requests.
module invaders_video_fetch #(
    parameter int          H_TOTAL   = 320,
    parameter int          H_ACTIVE  = 256,
    parameter int          V_TOTAL   = 262,
    parameter int          V_ACTIVE  = 224,
    parameter int          HS_START  = 272,
    parameter int          HS_LEN    = 32,
    parameter int          VS_START  = 234,
    parameter int          VS_LEN    = 4,
    parameter logic [15:0] VRAM_BASE = 16'h2400,
    parameter int          MID_LINE  = 96
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        ce_pix,
    output logic        vid_rd,
    output logic [15:0] vid_addr,
    input  logic [7:0]  Ram_out,
    output logic [10:0] color_prom_addr,
    input  logic [7:0]  color_prom_out,
    output logic        pix_on,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        int_req,
    output logic [7:0]  int_vec,
    input  logic        int_ack
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_PRE  = 9'(H_TOTAL - 2);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] H_FEND = 9'(H_ACTIVE - 8);
    localparam logic [8:0] HS_B   = 9'(HS_START);
    localparam logic [8:0] HS_E   = 9'(HS_START + HS_LEN);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] VS_B   = 9'(VS_START);
    localparam logic [8:0] VS_E   = 9'(VS_START + VS_LEN);
    localparam logic [8:0] V_MID  = 9'(MID_LINE);

    logic [8:0]  h, v, v_next;
    logic [7:0]  shifter, hold;
    logic        fetched, fetch_en, rd_d1, pix_s1;
    logic        fetch_slot, load_slot, f_go;
    logic [8:0]  f_line;
    logic [4:0]  f_col;
    logic [15:0] f_addr;
    logic        int_mid, int_end;
    logic        unused_color;

    assign unused_color = ^color_prom_out[7:3];

    always_comb begin
        v_next     = (v == V_LAST) ? 9'd0 : v + 9'd1;
        fetch_slot = ce_pix && (h[2:0] == 3'd6);
        load_slot  = ce_pix && (h[2:0] == 3'd7);
        f_line     = v;
        f_col      = h[7:3] + 5'd1;
        f_go       = 1'b0;
        if (fetch_slot && fetch_en && (h < H_FEND)) begin
            f_go = 1'b1;
        end else if (fetch_slot && (h == H_PRE)) begin
            // Column 0 of the next line is fetched during horizontal blanking.
            f_line = v_next;
            f_col  = 5'd0;
            f_go   = 1'b1;
        end
        if (f_line >= V_ACT) f_go = 1'b0;
        f_addr  = VRAM_BASE + {2'b00, f_line, 5'b00000} + {11'd0, f_col};
        int_mid = ce_pix && (h == 9'd0) && (v == V_MID);
        int_end = ce_pix && (h == 9'd0) && (v == V_ACT);
    end

    // vid_rd is a one-Clock strobe; the RAM answers on Ram_out during the
    // following Clock, which is captured into hold at the end of that Clock.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            h               <= 9'd0;
            v               <= 9'd0;
            shifter         <= 8'd0;
            hold            <= 8'd0;
            fetched         <= 1'b0;
            fetch_en        <= 1'b0;
            rd_d1           <= 1'b0;
            vid_rd          <= 1'b0;
            vid_addr        <= 16'd0;
            pix_s1          <= 1'b0;
            pix_on          <= 1'b0;
            color_prom_addr <= 11'd0;
            hsync           <= 1'b0;
            vsync           <= 1'b0;
            hblank          <= 1'b0;
            vblank          <= 1'b0;
            int_req         <= 1'b0;
            int_vec         <= 8'h00;
        end else begin
            vid_rd <= f_go;
            rd_d1  <= vid_rd;
            if (f_go) vid_addr <= f_addr;

            if (load_slot) hold <= 8'd0;
            else if (rd_d1) hold <= Ram_out;

            if (f_go) fetched <= 1'b1;
            else if (load_slot) fetched <= 1'b0;

            if (ce_pix) begin
                if (h == H_LAST) begin
                    h <= 9'd0;
                    v <= v_next;
                end else begin
                    h <= h + 9'd1;
                end
                // Fetches stay off after reset until the first full-line prefetch.
                if (h == H_PRE) fetch_en <= 1'b1;
                if (h[2:0] == 3'd7) shifter <= fetched ? hold : 8'd0;
                else shifter <= {1'b0, shifter[7:1]};
            end

            hsync           <= (h >= HS_B) && (h < HS_E);
            vsync           <= (v >= VS_B) && (v < VS_E);
            hblank          <= (h >= H_ACT);
            vblank          <= (v >= V_ACT);
            color_prom_addr <= {1'b0, v[7:3], h[7:3]};
            pix_s1          <= shifter[0] && (h < H_ACT) && (v < V_ACT);
            // Extra stage lines pix_on up with the colour RAM read of color_prom_addr.
            pix_on          <= pix_s1;

            if (int_mid) begin
                int_req <= 1'b1;
                int_vec <= 8'hCF;
            end else if (int_end) begin
                int_req <= 1'b1;
                int_vec <= 8'hD7;
            end else if (int_ack) begin
                int_req <= 1'b0;
            end
        end
    end

    assign r = pix_on & color_prom_out[0];
    assign b = pix_on & color_prom_out[1];
    assign g = pix_on & color_prom_out[2];

endmodule

// File: tb/tb_invaders_video_fetch.sv
// Bench for invaders_video_fetch: a full-size instance and a short-frame instance
// run in lockstep; fetch addresses go through a scoreboard queue per instance.
module tb_invaders_video_fetch;

    localparam int B_VT = 20, B_VA = 16, B_VS = 17, B_VSL = 2, B_MID = 6;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset_n, ce_pix, int_ack;
    logic        vid_rd_a, vid_rd_b;
    logic [15:0] vid_addr_a, vid_addr_b;
    logic [7:0]  ram_out_a, ram_out_b, cprom_out_a, cprom_out_b;
    logic [10:0] color_prom_addr_a, color_prom_addr_b;
    logic        pix_on_a, r_a, g_a, b_a, hsync_a, vsync_a, hblank_a, vblank_a, int_req_a;
    logic        pix_on_b, r_b, g_b, b_b, hsync_b, vsync_b, hblank_b, vblank_b, int_req_b;
    logic [7:0]  int_vec_a, int_vec_b;

    invaders_video_fetch u_a (
        .Clock(Clock), .Reset_n(Reset_n), .ce_pix(ce_pix),
        .vid_rd(vid_rd_a), .vid_addr(vid_addr_a), .Ram_out(ram_out_a),
        .color_prom_addr(color_prom_addr_a), .color_prom_out(cprom_out_a),
        .pix_on(pix_on_a), .r(r_a), .g(g_a), .b(b_a),
        .hsync(hsync_a), .vsync(vsync_a), .hblank(hblank_a), .vblank(vblank_a),
        .int_req(int_req_a), .int_vec(int_vec_a), .int_ack(int_ack)
    );

    invaders_video_fetch #(
        .V_TOTAL(B_VT), .V_ACTIVE(B_VA), .VS_START(B_VS), .VS_LEN(B_VSL), .MID_LINE(B_MID)
    ) u_b (
        .Clock(Clock), .Reset_n(Reset_n), .ce_pix(ce_pix),
        .vid_rd(vid_rd_b), .vid_addr(vid_addr_b), .Ram_out(ram_out_b),
        .color_prom_addr(color_prom_addr_b), .color_prom_out(cprom_out_b),
        .pix_on(pix_on_b), .r(r_b), .g(g_b), .b(b_b),
        .hsync(hsync_b), .vsync(vsync_b), .hblank(hblank_b), .vblank(vblank_b),
        .int_req(int_req_b), .int_vec(int_vec_b), .int_ack(int_ack)
    );

    logic [7:0]  mem [0:65535];
    logic [7:0]  cprom [0:2047];

    // RAM data is present only during the Clock after vid_rd.
    always @(posedge Clock) begin
        ram_out_a   <= vid_rd_a ? mem[vid_addr_a] : 8'h00;
        ram_out_b   <= vid_rd_b ? mem[vid_addr_b] : 8'h00;
        cprom_out_a <= cprom[color_prom_addr_a];
        cprom_out_b <= cprom[color_prom_addr_b];
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];
    int          tb_h, tb_va, tb_vb, gap;
    bit          fetch_en;
    logic        exp_req_a, exp_req_b;
    logic [7:0]  exp_vec_a, exp_vec_b;
    logic [15:0] pix5 = 16'h0381;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (h=%0d va=%0d vb=%0d)", name, act, exp, tb_h, tb_va, tb_vb);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {15'd0, act}, {15'd0, exp});
    endtask

    // Monitor: every vid_rd Clock must match the oldest expected address.
    always @(negedge Clock) begin
        if (Reset_n === 1'b1) begin
            if (vid_rd_a === 1'b1) begin
                if (exp_q_a.size() == 0) check1("vid_rd_a unexpected", vid_rd_a, 1'b0);
                else check("vid_addr_a", vid_addr_a, exp_q_a.pop_front());
                check1("vid_addr_a range", vid_addr_a > 16'h3FFF, 1'b0);
            end
            if (vid_rd_b === 1'b1) begin
                if (exp_q_b.size() == 0) check1("vid_rd_b unexpected", vid_rd_b, 1'b0);
                else check("vid_addr_b", vid_addr_b, exp_q_b.pop_front());
                check1("vid_addr_b range", vid_addr_b > 16'h3FFF, 1'b0);
            end
        end
    end

    task automatic push_fetch(input int v, input int vt, input int va, input bit inst_b);
        int line, col;
        bit go;
        go = 0; line = 0; col = 0;
        if (tb_h % 8 == 6) begin
            if (tb_h < 248 && fetch_en) begin
                line = v; col = tb_h / 8 + 1; go = 1;
            end else if (tb_h == 318) begin
                line = (v + 1) % vt; col = 0; go = 1;
            end
        end
        if (go && line < va) begin
            if (inst_b) exp_q_b.push_back(16'(32'h2400 + line * 32 + col));
            else exp_q_a.push_back(16'(32'h2400 + line * 32 + col));
        end
    endtask

    task automatic reset_model();
        tb_h = 0; tb_va = 0; tb_vb = 0; fetch_en = 0;
        exp_req_a = 0; exp_req_b = 0; exp_vec_a = 8'h00; exp_vec_b = 8'h00;
        exp_q_a.delete(); exp_q_b.delete();
    endtask

    task automatic check_idle();
        check("idle flags_a", {6'd0, vid_rd_a, pix_on_a, r_a, g_a, b_a, hsync_a, vsync_a, hblank_a, vblank_a, int_req_a}, 16'd0);
        check("idle flags_b", {6'd0, vid_rd_b, pix_on_b, r_b, g_b, b_b, hsync_b, vsync_b, hblank_b, vblank_b, int_req_b}, 16'd0);
        check("idle vid_addr_a", vid_addr_a, 16'd0);
        check("idle cprom_addr_a", {5'd0, color_prom_addr_a}, 16'd0);
        check("idle int_vec_a", {8'd0, int_vec_a}, 16'd0);
        check("idle int_vec_b", {8'd0, int_vec_b}, 16'd0);
    endtask

    task automatic check_pixel();
        int idx;
        logic p;
        check1("hsync_a", hsync_a, tb_h >= 272 && tb_h < 304);
        check1("hblank_a", hblank_a, tb_h >= 256);
        check1("vsync_a", vsync_a, tb_va >= 234 && tb_va < 238);
        check1("vblank_a", vblank_a, tb_va >= 224);
        check1("hsync_b", hsync_b, tb_h >= 272 && tb_h < 304);
        check1("vsync_b", vsync_b, tb_vb >= B_VS && tb_vb < B_VS + B_VSL);
        check1("vblank_b", vblank_b, tb_vb >= B_VA);
        check1("int_req_a", int_req_a, exp_req_a);
        check1("int_req_b", int_req_b, exp_req_b);
        check("int_vec_a", {8'd0, int_vec_a}, {8'd0, exp_vec_a});
        check("int_vec_b", {8'd0, int_vec_b}, {8'd0, exp_vec_b});
        check("cprom_addr_a", {5'd0, color_prom_addr_a}, 16'(((tb_va % 256) / 8) * 32 + (tb_h % 256) / 8));
        if (tb_h >= 256) check1("pix_on_a hblank", pix_on_a, 1'b0);
        if (tb_vb >= B_VA) check1("pix_on_b vblank", pix_on_b, 1'b0);
        if (tb_va == 5 && tb_h >= 24 && tb_h < 40) begin
            idx = tb_h - 24;
            p = pix5[idx];
            check1("pix_on_a line5", pix_on_a, p);
            check1("r_a line5", r_a, p && tb_h < 32);
            check1("g_a line5", g_a, p && tb_h < 32);
            check1("b_a line5", b_a, p && tb_h >= 32);
        end
    endtask

    task automatic pixel(input bit ack);
        push_fetch(tb_va, 262, 224, 1'b0);
        push_fetch(tb_vb, B_VT, B_VA, 1'b1);
        if (tb_h == 0 && tb_va == 96) begin exp_req_a = 1; exp_vec_a = 8'hCF; end
        else if (tb_h == 0 && tb_va == 224) begin exp_req_a = 1; exp_vec_a = 8'hD7; end
        else if (ack) exp_req_a = 0;
        if (tb_h == 0 && tb_vb == B_MID) begin exp_req_b = 1; exp_vec_b = 8'hCF; end
        else if (tb_h == 0 && tb_vb == B_VA) begin exp_req_b = 1; exp_vec_b = 8'hD7; end
        else if (ack) exp_req_b = 0;
        if (tb_h == 318) fetch_en = 1;
        ce_pix = 1'b1; int_ack = ack;
        @(posedge Clock); #1;
        ce_pix = 1'b0; int_ack = 1'b0;
        if (tb_h == 319) begin
            tb_h = 0; tb_va = (tb_va + 1) % 262; tb_vb = (tb_vb + 1) % B_VT;
        end else begin
            tb_h++;
        end
        repeat (gap - 1) @(posedge Clock);
        #1;
        check_pixel();
    endtask

    task automatic run_to(input bit use_b, input int v, input int h);
        int n;
        n = 0;
        while (!(((use_b ? tb_vb : tb_va) == v) && tb_h == h)) begin
            pixel(1'b0);
            n++;
            if (n > 120000) begin
                check1("run_to bound", tb_h == h, 1'b1);
                break;
            end
        end
    endtask

    task automatic ack_pulse();
        exp_req_a = 0; exp_req_b = 0;
        int_ack = 1'b1;
        @(posedge Clock); #1;
        int_ack = 1'b0;
        check1("int_req_a after ack", int_req_a, 1'b0);
        check1("int_req_b after ack", int_req_b, 1'b0);
        check("int_vec_b after ack", {8'd0, int_vec_b}, {8'd0, exp_vec_b});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = (i >= 16'h2400 && i <= 16'h3FFF) ? 8'hFF : 8'h00;
        mem[16'h24A3] = 8'h81;
        mem[16'h24A4] = 8'h03;
        for (int i = 0; i < 2048; i++) cprom[i] = 8'h00;
        cprom[3] = 8'h05;
        cprom[4] = 8'h02;

        Reset_n = 1'b0; ce_pix = 1'b0; int_ack = 1'b0; gap = 4;
        reset_model();
        repeat (3) @(posedge Clock);
        #1 check_idle();
        Reset_n = 1'b1;
        repeat (2) @(posedge Clock);
        #1 check_idle();

        // First lines: prefetch timing, line 5 pixel pattern and colours.
        run_to(1'b1, 7, 0);
        gap = 3;

        // Short frame: RST 1 then RST 2 without acknowledge, then ack.
        run_to(1'b1, B_VA, 0);
        pixel(1'b0);
        check("int_vec_b end", {8'd0, int_vec_b}, 16'h00D7);
        run_to(1'b1, 18, 10);
        ack_pulse();

        // Second frame: ack coinciding with the end-of-screen event.
        run_to(1'b1, 8, 0);
        ack_pulse();
        run_to(1'b1, B_VA, 0);
        pixel(1'b1);
        check1("int_req_b ack+event", int_req_b, 1'b1);
        check("int_vec_b ack+event", {8'd0, int_vec_b}, 16'h00D7);
        run_to(1'b1, B_VA, 5);
        ack_pulse();

        // Reset in mid-line, then fetches resume only at the line-end prefetch.
        run_to(1'b0, 50, 101);
        @(posedge Clock); #1;
        Reset_n = 1'b0;
        #1 check_idle();
        reset_model();
        repeat (2) @(posedge Clock);
        #1 Reset_n = 1'b1;
        @(posedge Clock); #1 check_idle();
        for (int i = 0; i < 330; i++) pixel(1'b0);

        check("exp_q_a drained", 16'(exp_q_a.size()), 16'd0);
        check("exp_q_b drained", 16'(exp_q_b.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
